// File: rtl/ppu_pkg.sv
// Shared PPU definitions: arbiter FSM states,
// palette window and VRAM mirroring constants.
package ppu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REN_RD,
    REN_WAIT,
    CPU_WR,
    CPU_RD,
    CPU_WAIT
  } arb_state_t;

  localparam logic [5:0]  PALETTE_BASE = 6'h3F;
  localparam logic [13:0] MIRROR_MASK  = 14'h2FFF;
  localparam int          RD_LAT_DEF   = 1;

endpackage

// File: rtl/ppu_cpu_addr_map.sv
// CPU-side PPU address mirroring: $3000-$3EFF
// folds onto $2000-$2EFF, palette window untouched.
module ppu_cpu_addr_map
  import ppu_pkg::*;
(
  input  logic [13:0] cpu_addr,
  output logic [13:0] ppu_addr
);

  // clear bit 12 in the nametable mirror window
  always_comb begin
    ppu_addr = cpu_addr;
    if (cpu_addr[13:12] == 2'b11 &&
        cpu_addr[13:8] != PALETTE_BASE)
      ppu_addr = cpu_addr & MIRROR_MASK;
  end

endmodule

// File: rtl/ppu_vram_arbiter.sv
// PPU memory port arbiter: renderer fetches take
// priority, CPU PPUDATA accesses fill idle cycles.
module ppu_vram_arbiter
  import ppu_pkg::*;
#(
  parameter int RD_LAT = RD_LAT_DEF,
  parameter int ADDR_W = 18
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ren_rd_req,
  input  logic [ADDR_W-1:0] ren_addr,
  output logic [7:0]        ren_rdata,
  output logic              ren_valid,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [13:0]       cpu_addr,
  input  logic [7:0]        cpu_wdata,
  output logic              cpu_ack,
  output logic [7:0]        cpu_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_re,
  output logic              mem_we,
  input  logic [7:0]        mem_rdata
);

  arb_state_t        state;
  logic [1:0]        cnt;
  logic              ren_rd_req_d;
  logic              ren_pend;
  logic [ADDR_W-1:0] ren_addr_q;
  logic [ADDR_W-1:0] ren_addr_sel;
  logic [13:0]       cpu_map;
  logic              ren_rise;
  logic              ren_go;
  logic              ren_grant;

  ppu_cpu_addr_map u_map (
    .cpu_addr (cpu_addr),
    .ppu_addr (cpu_map)
  );

  assign ren_rise = ren_rd_req & ~ren_rd_req_d;
  assign ren_go   = ren_rise | ren_pend;
  assign ren_grant = ren_go &&
    (state == IDLE || state == CPU_WAIT);
  // a fresh edge always carries the newest address
  assign ren_addr_sel = ren_rise ? ren_addr
                                 : ren_addr_q;

  // renderer edge detect and pending request latch
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ren_rd_req_d <= 1'b0;
      ren_pend     <= 1'b0;
      ren_addr_q   <= '0;
    end else begin
      ren_rd_req_d <= ren_rd_req;
      if (ren_rise)
        ren_addr_q <= ren_addr;
      if (ren_grant)
        ren_pend <= 1'b0;
      else if (ren_rise)
        ren_pend <= 1'b1;
    end
  end

  // arbitration FSM with registered memory/handshake outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= 2'd0;
      mem_re    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= 8'h00;
      cpu_ack   <= 1'b0;
      cpu_rdata <= 8'h00;
      ren_valid <= 1'b0;
      ren_rdata <= 8'h00;
    end else begin
      mem_re    <= 1'b0;
      mem_we    <= 1'b0;
      cpu_ack   <= 1'b0;
      ren_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (ren_go) begin
            state    <= REN_RD;
            mem_re   <= 1'b1;
            mem_addr <= ren_addr_sel;
          end else if (cpu_req && !cpu_ack) begin
            mem_addr <= {{(ADDR_W-14){1'b0}}, cpu_map};
            if (cpu_we) begin
              state     <= CPU_WR;
              mem_we    <= 1'b1;
              mem_wdata <= cpu_wdata;
            end else begin
              state  <= CPU_RD;
              mem_re <= 1'b1;
            end
          end
        end
        REN_RD: begin
          state <= REN_WAIT;
          cnt   <= 2'd1;
        end
        REN_WAIT: begin
          if (cnt == 2'(RD_LAT)) begin
            ren_rdata <= mem_rdata;
            ren_valid <= 1'b1;
            state     <= IDLE;
          end else begin
            cnt <= cnt + 2'd1;
          end
        end
        CPU_WR: begin
          cpu_ack <= cpu_req;
          state   <= IDLE;
        end
        CPU_RD: begin
          state <= CPU_WAIT;
          cnt   <= 2'd1;
        end
        CPU_WAIT: begin
          if (ren_go) begin
            state    <= REN_RD;
            mem_re   <= 1'b1;
            mem_addr <= ren_addr_sel;
          end else if (cnt == 2'(RD_LAT)) begin
            if (cpu_req) begin
              cpu_rdata <= mem_rdata;
              cpu_ack   <= 1'b1;
            end
            state <= IDLE;
          end else begin
            cnt <= cnt + 2'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/ppu_vram_arbiter.md
# ppu_vram_arbiter

Shares the single PPU memory port between the background rendering FSM (fixed-slot nametable/attribute/pattern fetches) and CPU-side PPUDATA accesses. The renderer always has priority and never waits more than one cycle. CPU accesses fill the free cycles and are aborted and retried when a renderer fetch collides with them. The block sits between the PPU register file / rendering FSM and the external PPU memory controller.

## Interface
- `RD_LAT`, default 1: cycles from the `mem_re` cycle to valid `mem_rdata`. Legal range 1–2.
- `ADDR_W`, default 18: width of the memory address.

Ports:
- `clk`  in  1  system clock (25 MHz)
- `rst`  in  1  asynchronous, active-low reset
- `ren_rd_req`  in  1  renderer read request; a level held 1–2 cycles; only its rising edge is a request
- `ren_addr`  in  ADDR_W  renderer address, sampled on the `ren_rd_req` rising edge
- `ren_rdata`  out  8  last renderer read data; holds its value between reads
- `ren_valid`  out  1  one-cycle pulse when `ren_rdata` updates
- `cpu_req`  in  1  CPU access request; held high until `cpu_ack`
- `cpu_we`  in  1  1 = write, 0 = read; stable while `cpu_req` is high
- `cpu_addr`  in  14  PPU address
- `cpu_wdata`  in  8  write data
- `cpu_ack`  out  1  one-cycle completion pulse
- `cpu_rdata`  out  8  read data; valid with `cpu_ack` and held afterwards
- `mem_addr`  out  ADDR_W  memory address (registered)
- `mem_wdata`  out  8  memory write data (registered)
- `mem_re`  out  1  one-cycle read strobe
- `mem_we`  out  1  one-cycle write strobe
- `mem_rdata`  in  8  memory read data

## Operation
- Renderer edge detect:
  - `ren_rise = ren_rd_req & ~ren_rd_req_d`.
  - On `ren_rise`, set `ren_pend` and latch `ren_addr`.
  - A second edge while `ren_pend` is set overwrites the latched address (last wins).
- CPU address mapping:
  - `cpu_addr[13:12]==2'b11` and `cpu_addr[13:8]!=6'h3F`: clear bit 12 (mirror $3000–$3EFF to $2000–$2EFF).
  - Result is zero-extended to ADDR_W.
- FSM states:
  - `IDLE`
    - `ren_pend` → `REN_RD`.
    - Else `cpu_req` & `cpu_we` → `CPU_WR`.
    - Else `cpu_req` & ~`cpu_we` → `CPU_RD`.
  - `REN_RD`: drive `mem_re=1` with the latched address; clear `ren_pend`; → `REN_WAIT`.
  - `REN_WAIT`: count RD_LAT cycles, then capture `mem_rdata` into `ren_rdata` and pulse `ren_valid`; → `IDLE`.
  - `CPU_WR`: drive `mem_we=1`; pulse `cpu_ack` next cycle; → `IDLE`. A write is atomic and cannot be preempted.
  - `CPU_RD`: drive `mem_re=1`; → `CPU_WAIT`.
  - `CPU_WAIT`
    - After RD_LAT cycles: capture into `cpu_rdata`, pulse `cpu_ack`; → `IDLE`.
    - If `ren_rise` or `ren_pend` occurs first: abort (no ack, no `cpu_rdata` update); → `REN_RD`. The CPU read is reissued from `IDLE` afterwards.
- Renderer and CPU request in the same cycle: the renderer wins.
- `cpu_req` dropped before ack: the in-flight access completes on memory but no `cpu_ack` is generated.
- Reset values: `mem_re`, `mem_we`, `cpu_ack`, `ren_valid` = 0; `mem_addr`, `mem_wdata`, `ren_rdata`, `cpu_rdata` = 0; `ren_pend`, `ren_rd_req_d` = 0; state = `IDLE`.
- Reset mid-access: outputs return to their reset values asynchronously. The aborted access is lost and never acked.

## Timing
- All outputs are registered.
- Renderer latency, with `ren_rise` in cycle t:
  - No conflict: `mem_re` in t+1, `ren_valid` in t+2+RD_LAT.
  - CPU write in progress at t: +1 cycle.
  - This meets the renderer's data-take point (3 cycles after request) for RD_LAT=1.
- CPU write: `mem_we` 1 cycle after grant; `cpu_ack` 1 cycle after `mem_we`.
- CPU read: `mem_re` 1 cycle after grant; `cpu_ack` 1+RD_LAT cycles after `mem_re`.
- `mem_re` and `mem_we` are never high together and are never high on consecutive cycles for different owners without a state transition.

## Structure
- Shared package `ppu_pkg`: FSM state encodings, `PALETTE_BASE` (6'h3F), the mirror mask, and the default RD_LAT.
- Natural sub-module: `ppu_cpu_addr_map` (combinational mirroring), reusable by the palette logic.

## Test plan
- Idle renderer, CPU read at 14'h2005 with mem returning 8'hA5 → `mem_addr`=18'h02005, `mem_re` one cycle, `cpu_ack` with `cpu_rdata`=8'hA5 after 1+RD_LAT cycles.
- CPU write to 14'h3123, data 8'h5C → `mem_we` once with `mem_addr`=18'h02123, `mem_wdata`=8'h5C, then `cpu_ack`. Address 14'h3F10 → passed unchanged.
- Renderer 8-cycle slot pattern (req held 2 cycles) for 32 fetches, no CPU → exactly 32 `mem_re` and 32 `ren_valid`, each at t+2+RD_LAT.
- CPU read issued, renderer edge arrives in `CPU_WAIT` → renderer served on time, CPU read reissued, a single `cpu_ack` with the correct data.
- Renderer edge coincident with a CPU write grant → write completes, `mem_re` for renderer one cycle late, `ren_valid` at t+3+RD_LAT.
- `rst` asserted during `REN_WAIT` → all outputs 0 immediately; after release, no stale `ren_valid` or `cpu_ack`.
